// File: rtl/key_loader_pkg.sv
// key_loader_pkg
// Shared definitions for the key loader: FSM state encoding, key field
// layout of the locked netlist and the default decoy key.
//   Key layout: key[P_LSB +: P_W] = p1..p4 (mux selects)
//               key[X_LSB +: X_W] = X_1..X_9 (XOR keys)
package key_loader_pkg;

  localparam int KEY_W_DEF     = 13;
  localparam int MAX_RETRY_DEF = 3;
  localparam int RETRY_W_DEF   = 2;

  localparam int P_LSB = 0;
  localparam int P_W   = 4;
  localparam int X_LSB = 4;
  localparam int X_W   = 9;

  localparam logic [KEY_W_DEF-1:0] DECOY_KEY_DEF = 13'h1555;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CHECK   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

endpackage

// File: rtl/key_shift_rx.sv
// key_shift_rx
// Serial-to-parallel receiver for the key stream. Bits arrive LSB first;
// the first KEY_W accepted bits fill o_shreg, the next one is the parity
// bit. o_done pulses (combinationally) on the edge that accepts parity.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   i_en           receiver is allowed to accept bits (loader in SHIFT)
//   i_restart      clear counter and shift register; wins over accept
//   i_sdi_data     serial data bit
//   i_sdi_valid    serial data valid
//   o_shreg        collected key bits (internal to the loader)
//   o_par_bit      captured parity bit
//   o_done         parity bit is being accepted this cycle
module key_shift_rx #(
  parameter  int KEY_W = 13,
  localparam int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic             i_sdi_data,
  input  logic             i_sdi_valid,
  output logic [KEY_W-1:0] o_shreg,
  output logic             o_par_bit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_bit_cnt;
  logic [KEY_W-1:0] r_shreg;
  logic             r_par_bit;
  logic             w_accept;

  // A bit arriving on a restart edge is dropped so the new load starts clean.
  assign w_accept = i_en && i_sdi_valid && !i_restart;
  assign o_done   = w_accept && (r_bit_cnt == CNT_W'(KEY_W));
  assign o_shreg  = r_shreg;
  assign o_par_bit = r_par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_par_bit <= 1'b0;
    end else if (i_restart) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else if (w_accept) begin
      if (r_bit_cnt < CNT_W'(KEY_W)) begin
        r_shreg[r_bit_cnt] <= i_sdi_data;
      end else begin
        r_par_bit <= i_sdi_data;
      end
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_loader.sv
// key_loader
// Loads the unlock key of a logic-locked netlist from secure storage over
// a serial valid/ready link, verifies it with even parity and only then
// presents it on o_key_out. Until a verified key is held the bus carries a
// decoy key. MAX_RETRY consecutive failed checks lock the block until reset.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_load_start     start (or restart) a key load
//   i_clear_key      zeroize: drop the key, back to decoy and IDLE
//   i_sdi_data       serial key bit, LSB first, parity bit last
//   i_sdi_valid      serial bit valid
//   o_sdi_ready      loader accepts a bit (only in SHIFT)
//   o_key_out        parallel key bus
//   o_key_ready      o_key_out holds a verified key
//   o_key_err        last load failed parity (sticky until next load_start)
//   o_lockout        permanently locked until reset
//   o_dbg_state      current FSM state
//
// Link handshake: a bit transfers on every rising edge where both
// i_sdi_valid and o_sdi_ready are high; either side may hold its signal low
// for any number of cycles, and the sender keeps i_sdi_data stable while
// i_sdi_valid is high and o_sdi_ready is low.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int               KEY_W     = KEY_W_DEF,
  parameter logic [KEY_W-1:0] DECOY_KEY = DECOY_KEY_DEF,
  parameter int               MAX_RETRY = MAX_RETRY_DEF,
  parameter int               RETRY_W   = RETRY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load_start,
  input  logic             i_clear_key,
  input  logic             i_sdi_data,
  input  logic             i_sdi_valid,
  output logic             o_sdi_ready,
  output logic [KEY_W-1:0] o_key_out,
  output logic             o_key_ready,
  output logic             o_key_err,
  output logic             o_lockout,
  output logic [1:0]       o_dbg_state
);

  state_t             r_state, w_state_nxt;
  logic [KEY_W-1:0]   r_key_out, w_key_out_nxt;
  logic               r_key_ready, w_key_ready_nxt;
  logic               r_key_err, w_key_err_nxt;
  logic               r_lockout, w_lockout_nxt;
  logic [RETRY_W-1:0] r_retry_cnt, w_retry_cnt_nxt;
  logic [RETRY_W-1:0] w_retry_inc;

  logic [KEY_W-1:0]   w_shreg;
  logic               w_par_bit;
  logic               w_done;
  logic               w_restart;
  logic               w_parity_ok;

  // Any path that abandons the current load (clear, or a fresh start from
  // IDLE/SHIFT) also wipes the receiver. CHECK ignores load_start.
  assign w_restart = (r_state != LOCKOUT) &&
                     (i_clear_key ||
                      (i_load_start && (r_state == IDLE || r_state == SHIFT)));

  assign w_parity_ok = ~(^{w_shreg, w_par_bit});
  assign w_retry_inc = r_retry_cnt + 1'b1;

  key_shift_rx #(
    .KEY_W(KEY_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (r_state == SHIFT),
    .i_restart   (w_restart),
    .i_sdi_data  (i_sdi_data),
    .i_sdi_valid (i_sdi_valid),
    .o_shreg     (w_shreg),
    .o_par_bit   (w_par_bit),
    .o_done      (w_done)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_key_out_nxt   = r_key_out;
    w_key_ready_nxt = r_key_ready;
    w_key_err_nxt   = r_key_err;
    w_lockout_nxt   = r_lockout;
    w_retry_cnt_nxt = r_retry_cnt;
    case (r_state)
      IDLE: begin
        if (i_clear_key) begin
          w_key_out_nxt   = DECOY_KEY;
          w_key_ready_nxt = 1'b0;
        end else if (i_load_start) begin
          w_state_nxt     = SHIFT;
          w_key_out_nxt   = DECOY_KEY;
          w_key_ready_nxt = 1'b0;
          w_key_err_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (i_clear_key) begin
          w_state_nxt     = IDLE;
          w_key_out_nxt   = DECOY_KEY;
          w_key_ready_nxt = 1'b0;
        end else if (i_load_start) begin
          w_state_nxt = SHIFT;
        end else if (w_done) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (i_clear_key) begin
          // Zeroize discards the pending check result entirely.
          w_state_nxt     = IDLE;
          w_key_out_nxt   = DECOY_KEY;
          w_key_ready_nxt = 1'b0;
        end else if (w_parity_ok) begin
          w_state_nxt     = IDLE;
          w_key_out_nxt   = w_shreg;
          w_key_ready_nxt = 1'b1;
          w_retry_cnt_nxt = '0;
        end else begin
          w_key_err_nxt   = 1'b1;
          w_retry_cnt_nxt = w_retry_inc;
          if (w_retry_inc == RETRY_W'(MAX_RETRY)) begin
            w_state_nxt   = LOCKOUT;
            w_lockout_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      LOCKOUT: begin
        w_key_out_nxt   = DECOY_KEY;
        w_key_ready_nxt = 1'b0;
        w_lockout_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_out   <= DECOY_KEY;
      r_key_ready <= 1'b0;
      r_key_err   <= 1'b0;
      r_lockout   <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_key_out   <= w_key_out_nxt;
      r_key_ready <= w_key_ready_nxt;
      r_key_err   <= w_key_err_nxt;
      r_lockout   <= w_lockout_nxt;
      r_retry_cnt <= w_retry_cnt_nxt;
    end
  end

  assign o_sdi_ready = (r_state == SHIFT);
  assign o_key_out   = r_key_out;
  assign o_key_ready = r_key_ready;
  assign o_key_err   = r_key_err;
  assign o_lockout   = r_lockout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader
// Directed bench for key_loader: a table of complete loads with expected
// results, followed by hand-written lockout, abort and clear sequences.
module tb_key_loader;

  localparam logic [12:0] DECOY = 13'h1555;

  logic        clk;
  logic        rst_n;
  logic        i_load_start;
  logic        i_clear_key;
  logic        i_sdi_data;
  logic        i_sdi_valid;
  logic        o_sdi_ready;
  logic [12:0] o_key_out;
  logic        o_key_ready;
  logic        o_key_err;
  logic        o_lockout;
  logic [1:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  key_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (i_load_start),
    .i_clear_key  (i_clear_key),
    .i_sdi_data   (i_sdi_data),
    .i_sdi_valid  (i_sdi_valid),
    .o_sdi_ready  (o_sdi_ready),
    .o_key_out    (o_key_out),
    .o_key_ready  (o_key_ready),
    .o_key_err    (o_key_err),
    .o_lockout    (o_lockout),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Starts a load, streams key LSB first then parity, and checks the
  // cycle right after the parity edge (CHECK). Returns one edge later,
  // when the check result is visible on the outputs.
  task automatic send_key(input logic [12:0] key, input logic par, input logic stall);
    logic ok_ready;
    logic b;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    ok_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      b = (i < 13) ? key[i] : par;
      if (stall) begin
        i_sdi_valid = 1'b0;
        i_sdi_data  = ~b;
        tick();
      end
      i_sdi_valid = 1'b1;
      i_sdi_data  = b;
      if (o_sdi_ready !== 1'b1) ok_ready = 1'b0;
      tick();
    end
    i_sdi_valid = 1'b0;
    i_sdi_data  = 1'b0;
    check("sdi_ready_during_shift", 32'(ok_ready), 32'd1);
    check("sdi_ready_in_check", 32'(o_sdi_ready), 32'd0);
    check("state_check", 32'(o_dbg_state), 32'd2);
    check("key_ready_before_check", 32'(o_key_ready), 32'd0);
    check("key_out_before_check", 32'(o_key_out), 32'(DECOY));
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [12:0] key;
    logic        par;
    logic        stall;
    logic [12:0] exp_key;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_lock;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // key, parity, stall -> key_out, key_ready, key_err, lockout
    vecs[0] = '{13'h0A5B, 1'b1, 1'b0, 13'h0A5B, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{13'h0A5B, 1'b1, 1'b1, 13'h0A5B, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{13'h0A5B, 1'b0, 1'b0, DECOY,    1'b0, 1'b1, 1'b0};
    vecs[3] = '{13'h0A5B, 1'b1, 1'b0, 13'h0A5B, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{13'h0000, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{13'h1FFF, 1'b0, 1'b1, DECOY,    1'b0, 1'b1, 1'b0};
    vecs[6] = '{13'h0001, 1'b0, 1'b0, DECOY,    1'b0, 1'b1, 1'b0};
    vecs[7] = '{13'h1000, 1'b1, 1'b0, 13'h1000, 1'b1, 1'b0, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    i_load_start = 1'b0;
    i_clear_key  = 1'b0;
    i_sdi_data   = 1'b0;
    i_sdi_valid  = 1'b0;
    rst_n        = 1'b0;
    #1;
    do_reset();
    repeat (5) tick();
    check("rst_key_out", 32'(o_key_out), 32'(DECOY));
    check("rst_key_ready", 32'(o_key_ready), 32'd0);
    check("rst_sdi_ready", 32'(o_sdi_ready), 32'd0);
    check("rst_lockout", 32'(o_lockout), 32'd0);
    check("rst_key_err", 32'(o_key_err), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);

    for (int v = 0; v < 8; v++) begin
      send_key(vecs[v].key, vecs[v].par, vecs[v].stall);
      check($sformatf("vec%0d_key_out", v), 32'(o_key_out), 32'(vecs[v].exp_key));
      check($sformatf("vec%0d_key_ready", v), 32'(o_key_ready), 32'(vecs[v].exp_ready));
      check($sformatf("vec%0d_key_err", v), 32'(o_key_err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_lockout", v), 32'(o_lockout), 32'(vecs[v].exp_lock));
      check($sformatf("vec%0d_state_idle", v), 32'(o_dbg_state), 32'd0);
    end

    // Held key survives idle cycles.
    repeat (4) tick();
    check("hold_key_out", 32'(o_key_out), 32'h1000);
    check("hold_key_ready", 32'(o_key_ready), 32'd1);

    // Three consecutive bad loads (retry count was cleared by vec 7).
    for (int n = 1; n <= 3; n++) begin
      send_key(13'h0A5B, 1'b0, 1'b0);
      check($sformatf("bad%0d_lockout", n), 32'(o_lockout), (n == 3) ? 32'd1 : 32'd0);
      check($sformatf("bad%0d_key_err", n), 32'(o_key_err), 32'd1);
    end
    check("lock_state", 32'(o_dbg_state), 32'd3);
    check("lock_key_out", 32'(o_key_out), 32'(DECOY));
    check("lock_key_ready", 32'(o_key_ready), 32'd0);

    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    tick();
    check("lock_load_sdi_ready", 32'(o_sdi_ready), 32'd0);
    check("lock_load_state", 32'(o_dbg_state), 32'd3);
    i_clear_key = 1'b1;
    tick();
    i_clear_key = 1'b0;
    tick();
    check("lock_clear_lockout", 32'(o_lockout), 32'd1);
    check("lock_clear_key_err", 32'(o_key_err), 32'd1);

    // Asynchronous reset assertion clears lockout without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_lockout", 32'(o_lockout), 32'd0);
    check("async_rst_key_err", 32'(o_key_err), 32'd0);
    check("async_rst_state", 32'(o_dbg_state), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Abort after 6 bits; the bit offered on the restart edge is discarded.
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_sdi_valid = 1'b1;
      i_sdi_data  = 1'b1;
      tick();
    end
    i_sdi_valid = 1'b1;
    i_sdi_data  = 1'b0;
    send_key(13'h1FFF, 1'b1, 1'b0);
    check("abort_key_out", 32'(o_key_out), 32'h1FFF);
    check("abort_key_ready", 32'(o_key_ready), 32'd1);
    check("abort_key_err", 32'(o_key_err), 32'd0);

    // clear_key wins over load_start on the same edge.
    i_clear_key  = 1'b1;
    i_load_start = 1'b1;
    tick();
    i_clear_key  = 1'b0;
    i_load_start = 1'b0;
    check("clear_key_out", 32'(o_key_out), 32'(DECOY));
    check("clear_key_ready", 32'(o_key_ready), 32'd0);
    check("clear_state", 32'(o_dbg_state), 32'd0);
    check("clear_sdi_ready", 32'(o_sdi_ready), 32'd0);
    tick();
    check("clear_state_stays", 32'(o_dbg_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
